pixel_stream_arbiter: RTL and testbench
=======================================

// Module: pixel_stream_arbiter
// PURPOSE
//  Shares the framebuffer pixel-write path between NUM_SOURCES Avalon-ST pixel producers
//  (rasteriser, blitter, clear engine, ...). It merges them into one Avalon-ST stream that
//  feeds the framebuffer writer sink. Arbitration is round-robin with a bounded per-grant burst
//  (GRANT_HOLD beats), so a busy source cannot starve the others.
//  Output is fully registered: one beat per cycle, 1-cycle latency.
// PARAMETERS
//  NUM_SOURCES  4                 number of pixel sources, 2..8
//  GRANT_HOLD   16                max consecutive beats granted to one source before rotating, >=1
//  DATA_W       ST_DATA_WIDTH     pixel beat width (graphics_pkg pixel_t)
// PORTS
//  clk          in   1                       clock
//  reset        in   1                       reset, synchronous, active-high
//  in_valid     in   NUM_SOURCES             per-source beat valid
//  in_data      in   NUM_SOURCES*DATA_W      per-source pixel; source i at [i*DATA_W +: DATA_W]
//  in_channel   in   NUM_SOURCES*8           per-source channel; source i at [i*8 +: 8]
//  in_ready     out  NUM_SOURCES             per-source ready (combinational)
//  out_valid    out  1                       merged beat valid (registered)
//  out_data     out  DATA_W                  merged pixel (registered)
//  out_channel  out  8                       channel of the accepted beat, passed through unchanged
//  out_source   out  $clog2(NUM_SOURCES)     index of the source that produced out_data
//  out_ready    in   1                       downstream ready (framebuffer writer st_ready)
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_channel=0, out_source=0, grant=0, hold_cnt=0.
//    in_ready is all-zero while reset=1.
//  - Load condition: load_en = !out_valid || out_ready. The output register accepts a new beat
//    only when load_en=1; it holds data stable while out_valid && !out_ready.
//  - Selection, evaluated combinationally each cycle; result sel:
//     * Keep: sel = grant if in_valid[grant] && hold_cnt < GRANT_HOLD.
//     * Rotate: otherwise sel = first i with in_valid[i], scanning grant+1, grant+2, ... modulo
//       NUM_SOURCES. The scan ends with grant itself, so a lone requester is re-granted even at
//       the hold limit.
//     * No in_valid asserted: no selection.
//  - in_ready[i] = !reset && load_en && (i == sel) && any(in_valid). At most one bit is set,
//    never more than one.
//  - Transfer: a transfer on source i occurs when in_valid[i] && in_ready[i]. On a transfer:
//     * out_valid<=1, out_data<=in_data[sel], out_channel<=in_channel[sel], out_source<=sel.
//     * If sel==grant: hold_cnt<=hold_cnt+1. Otherwise: grant<=sel, hold_cnt<=1.
//  - If load_en && no transfer: out_valid<=0; grant and hold_cnt are unchanged.
//  - If !load_en: nothing changes; all in_ready=0.
//  - Re-grant at the hold limit (lone requester): grant stays, hold_cnt<=1.
//  - hold_cnt is $clog2(GRANT_HOLD+1) bits and never exceeds GRANT_HOLD. With GRANT_HOLD=1 the
//    block is pure per-beat round-robin.
//  - Throughput: 1 beat/cycle when out_ready is held high. Latency: input acceptance to
//    out_valid is 1 cycle.
//  - A source may drop in_valid while not granted; no beat is lost or duplicated.
//    A beat that has been granted is consumed that same cycle.
//  - Reset asserted mid-stream: the pending out beat is discarded and no in_ready is given.
//    After reset the arbiter restarts from grant=0; sources must re-present their beats.
//  - No combinational path from out_ready to out_valid/out_data. One path exists,
//    out_ready -> in_ready, and it is allowed.
// TESTING
//  1. Reset with all in_valid=1 -> in_ready=0, out_valid=0. First cycle after reset:
//     src0 granted, out_source=0 one cycle later.
//  2. NUM_SOURCES=4, GRANT_HOLD=1, all valid, out_ready=1 -> out_source sequence 0,1,2,3,0,...;
//     one beat every cycle.
//  3. GRANT_HOLD=16, src1 and src2 continuously valid -> 16 beats from src1, then 16 from src2,
//     then back to src1.
//  4. Only src3 valid, GRANT_HOLD=4, 10 beats -> all 10 accepted back-to-back; hold_cnt wraps
//     to 1 at beat 5 and beat 9.
//  5. out_ready=0 for 5 cycles with a beat held (x=10,y=20) -> out_data stable and in_ready=0
//     throughout; released the cycle out_ready=1.
//  6. Reset pulsed while out_valid=1, out_ready=0 -> out_valid=0 the next cycle. The scoreboard
//     sees no beat emitted before reset that was not consumed downstream.

Source files
------------

// File: rtl/pixel_stream_arbiter.sv
// Round-robin merge of NUM_SOURCES Avalon-ST pixel producers into one registered stream.
// Each grant is held for at most GRANT_HOLD consecutive beats before the grant rotates.
module pixel_stream_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int GRANT_HOLD  = 16,
    parameter int DATA_W      = 24
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_SOURCES-1:0]               in_valid,
    input  logic [NUM_SOURCES*DATA_W-1:0]        in_data,
    input  logic [NUM_SOURCES*8-1:0]             in_channel,
    output logic [NUM_SOURCES-1:0]               in_ready,
    output logic                                 out_valid,
    output logic [DATA_W-1:0]                    out_data,
    output logic [7:0]                           out_channel,
    output logic [$clog2(NUM_SOURCES)-1:0]       out_source,
    input  logic                                 out_ready
);

    localparam int SRC_W  = $clog2(NUM_SOURCES);
    localparam int HOLD_W = $clog2(GRANT_HOLD + 1);

    logic [SRC_W-1:0]  grant;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SRC_W-1:0]  sel;
    logic              sel_found;
    logic              hold_ok;
    logic              load_en;
    logic              transfer;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [7:0]        channel_p1;
    logic [SRC_W-1:0]  source_p1;

    function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base, input int step);
        int s;
        s = (int'(base) + step) % NUM_SOURCES;
        return SRC_W'(s);
    endfunction

    assign hold_ok  = hold_cnt < HOLD_W'(GRANT_HOLD);
    assign load_en  = !vld_p1 || out_ready;
    assign transfer = !reset && load_en && sel_found;

    // Scan starts after the current grant and ends on it, so a lone requester is re-granted.
    always_comb begin
        sel       = grant;
        sel_found = 1'b0;
        if (in_valid[grant] && hold_ok) begin
            sel_found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_SOURCES; k++) begin
                if (!sel_found && in_valid[rr_index(grant, k)]) begin
                    sel       = rr_index(grant, k);
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[sel] = 1'b1;
        end
    end

    // Stage p1: output register, also the arbitration state update
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            channel_p1 <= '0;
            source_p1  <= '0;
            grant      <= '0;
            hold_cnt   <= '0;
        end else if (load_en) begin
            vld_p1 <= transfer;
            if (transfer) begin
                data_p1    <= in_data[sel*DATA_W +: DATA_W];
                channel_p1 <= in_channel[sel*8 +: 8];
                source_p1  <= sel;
                if (sel != grant) begin
                    grant    <= sel;
                    hold_cnt <= HOLD_W'(1);
                end else if (hold_ok) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end else begin
                    hold_cnt <= HOLD_W'(1);
                end
            end
        end
    end

    assign out_valid   = vld_p1;
    assign out_data    = data_p1;
    assign out_channel = channel_p1;
    assign out_source  = source_p1;

endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Bench for pixel_stream_arbiter: three instances (GRANT_HOLD 1, 16, 4) share the stimulus;
// each test watches one instance through a queue of expected beats.
module tb_pixel_stream_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [95:0] in_data = '0;
    logic [31:0] in_channel = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  ir [3];
    logic [2:0]  ov;
    logic [23:0] od [3];
    logic [7:0]  oc [3];
    logic [1:0]  os [3];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        pixel_stream_arbiter #(
            .NUM_SOURCES(4),
            .GRANT_HOLD ((g == 0) ? 1 : ((g == 1) ? 16 : 4)),
            .DATA_W     (24)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_data    (in_data),
            .in_channel (in_channel),
            .in_ready   (ir[g]),
            .out_valid  (ov[g]),
            .out_data   (od[g]),
            .out_channel(oc[g]),
            .out_source (os[g]),
            .out_ready  (out_ready)
        );
    end

    typedef struct {
        logic [3:0] v;
        logic       ordy;
        logic [3:0] exp_ir;
        int         exp_src;
    } vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          beats_seen = 0;
    int          mi = 0;
    int          tag = 0;
    logic [33:0] exp_q [$];
    vec_t        tbl [10];

    function automatic logic [33:0] beat(input int src, input int t);
        return {2'(src), 4'(src), 20'(t), 8'(8'h40 + src)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic r);
        tag++;
        in_valid  = v;
        out_ready = r;
        for (int i = 0; i < 4; i++) begin
            in_data[i*24 +: 24]  = {4'(i), 20'(tag)};
            in_channel[i*8 +: 8] = 8'(8'h40 + i);
        end
    endtask

    // Downstream consumes a beat at the coming edge when out_valid && out_ready.
    task automatic tick();
        @(negedge clk);
        if (ov[mi] && out_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h, expected none", {os[mi], od[mi], oc[mi]});
            end else begin
                chk("beat", {30'd0, os[mi], od[mi], oc[mi]}, {30'd0, exp_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        drive(4'b0000, 1'b1);
        tick();
        tick();
        chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b1111, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1};
        tbl[2] = '{4'b0101, 1'b1, 4'b0100, 2};
        tbl[3] = '{4'b0101, 1'b0, 4'b0000, -1};
        tbl[4] = '{4'b0101, 1'b1, 4'b0001, 0};
        tbl[5] = '{4'b0000, 1'b1, 4'b0000, -1};
        tbl[6] = '{4'b1000, 1'b0, 4'b1000, 3};
        tbl[7] = '{4'b0001, 1'b1, 4'b0001, 0};
        tbl[8] = '{4'b0001, 1'b1, 4'b0001, 0};
        tbl[9] = '{4'b0110, 1'b1, 4'b0010, 1};

        @(posedge clk);
        #1;

        // Reset with every source requesting, then src0 is first
        mi = 2;
        reset = 1'b1;
        drive(4'b1111, 1'b0);
        tick();
        tick();
        chk("reset_in_ready", 64'(ir[2]), 64'h0);
        chk("reset_out_valid", 64'(ov[2]), 64'h0);
        chk("reset_out_source", 64'(os[2]), 64'h0);
        reset = 1'b0;
        drive(4'b1111, 1'b1);
        #1;
        chk("first_in_ready", 64'(ir[2]), 64'h1);
        exp_q.push_back(beat(0, tag));
        tick();
        chk("first_out_valid", 64'(ov[2]), 64'h1);
        chk("first_out_source", 64'(os[2]), 64'h0);
        drain("t1");

        // Table vectors on the per-beat round-robin instance
        mi = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(ir[0]), 64'(tbl[i].exp_ir));
            if (tbl[i].exp_src >= 0) exp_q.push_back(beat(tbl[i].exp_src, tag));
            tick();
        end
        drain("table");

        // GRANT_HOLD=1, all valid: 0,1,2,3,... one beat per cycle
        mi = 0;
        do_reset();
        beats_seen = 0;
        for (int k = 0; k < 12; k++) begin
            drive(4'b1111, 1'b1);
            exp_q.push_back(beat(k % 4, tag));
            tick();
        end
        drive(4'b0000, 1'b1);
        tick();
        chk("rr_throughput", 64'(beats_seen), 64'd12);
        drain("t2");

        // GRANT_HOLD=16, src1 and src2: 16 from src1, 16 from src2, back to src1
        mi = 1;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            drive(4'b0110, 1'b1);
            exp_q.push_back(beat((k < 16) ? 1 : ((k < 32) ? 2 : 1), tag));
            tick();
        end
        drain("t3");

        // GRANT_HOLD=4, lone src3: ten back-to-back beats through two hold-limit re-grants
        mi = 2;
        do_reset();
        beats_seen = 0;
        for (int k = 0; k < 10; k++) begin
            drive(4'b1000, 1'b1);
            #1;
            chk($sformatf("lone_in_ready%0d", k), 64'(ir[2]), 64'h8);
            exp_q.push_back(beat(3, tag));
            tick();
        end
        drive(4'b0000, 1'b1);
        tick();
        chk("lone_throughput", 64'(beats_seen), 64'd10);
        drain("t4");

        // Backpressure: beat (x=10,y=20) held for five stalled cycles
        mi = 2;
        do_reset();
        drive(4'b0001, 1'b0);
        in_data[23:0] = {12'd10, 12'd20};
        #1;
        chk("bp_load_in_ready", 64'(ir[2]), 64'h1);
        exp_q.push_back({2'd0, 12'd10, 12'd20, 8'h40});
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 1'b0);
            #1;
            chk($sformatf("bp_in_ready%0d", k), 64'(ir[2]), 64'h0);
            chk($sformatf("bp_out_data%0d", k), 64'(od[2]), 64'h00A014);
            chk($sformatf("bp_out_valid%0d", k), 64'(ov[2]), 64'h1);
            tick();
        end
        drive(4'b0001, 1'b1);
        #1;
        chk("bp_release_in_ready", 64'(ir[2]), 64'h1);
        exp_q.push_back(beat(0, tag));
        tick();
        drain("t5");

        // Reset while a stalled beat is pending: it must vanish
        mi = 2;
        do_reset();
        drive(4'b0001, 1'b0);
        tick();
        chk("pre_reset_out_valid", 64'(ov[2]), 64'h1);
        reset = 1'b1;
        drive(4'b0001, 1'b0);
        #1;
        chk("in_reset_in_ready", 64'(ir[2]), 64'h0);
        tick();
        chk("post_reset_out_valid", 64'(ov[2]), 64'h0);
        reset = 1'b0;
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
